blake2_msg_sequencer: RTL and testbench

Parametrised message front-end for the blake2b core. Accepts a stream of message blocks from the host into a DEPTH-deep block FIFO, tracks the cumulative byte length, and drives the core's init/next/final command interface one block at a time. Captures the digest when the core reports it. Sits between the host/bus adapter and the blake2b core, and replaces hand-driven init/next/final sequencing.

---
 rtl/blake2_ctrl_pkg.sv | 28 ++
 rtl/blake2_block_fifo.sv | 64 ++++++
 rtl/blake2_msg_sequencer.sv | 165 ++++++++++++++++
 tb/tb_blake2_msg_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2_ctrl_pkg.sv
// Shared types and helpers for the blake2b message sequencer.
package blake2_ctrl_pkg;

   // Widest block the sequencer handles. The FIFO entry is sized for it, and
   // narrower BLOCK_W settings leave the upper bits at constant zero.
   localparam int unsigned MAX_BLOCK_W = 1024;
   localparam int unsigned MAX_BYTES_W = 8;

   // Bytes carried by one full block.
   function automatic int unsigned block_bytes(input int unsigned block_w);
      return block_w / 8;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_ACK,
      ST_WAIT,
      ST_DIGEST
   } state_t;

   typedef struct packed {
      logic [MAX_BLOCK_W-1:0] block;
      logic                   last;
      logic [MAX_BYTES_W-1:0] bytes;
   } fifo_entry_t;

endpackage

// File: rtl/blake2_block_fifo.sv
// Synchronous block FIFO with registered count and full/empty flags.
// A push is refused whenever the FIFO is full, even if a pop happens in the
// same cycle, so the accept decision depends only on registered state.
module blake2_block_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic             push_ok, pop_ok;

   assign push_ok = push && !full_q;
   assign pop_ok  = pop && !empty_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign full    = full_q;
   assign empty   = empty_q;

   // Next pointers, occupancy and flags; pointers wrap naturally (DEPTH is 2^n).
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      full_d   = (count_d == CNT_W'(DEPTH));
      empty_d  = (count_d == '0);
   end

   // Control state; reset drops all stored blocks.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage array, data only, no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/blake2_msg_sequencer.sv
// Message front-end for the blake2b core: buffers host blocks, tracks the
// cumulative byte length and issues init/next/final one block at a time.
module blake2_msg_sequencer
   import blake2_ctrl_pkg::*;
#(
   parameter int BLOCK_W  = 1024,
   parameter int DEPTH    = 8,
   parameter int LEN_W    = 128,
   parameter int DIGEST_W = 88
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [BLOCK_W-1:0]                in_block,
   input  logic                              in_last,
   input  logic [$clog2(BLOCK_W/8+1)-1:0]    in_bytes,
   output logic                              core_init,
   output logic                              core_next,
   output logic                              core_final,
   output logic [BLOCK_W-1:0]                core_block,
   output logic [LEN_W-1:0]                  core_length,
   input  logic                              core_ready,
   input  logic                              core_digest_valid,
   input  logic [DIGEST_W-1:0]               core_digest,
   output logic                              digest_valid,
   output logic [DIGEST_W-1:0]               digest,
   output logic                              busy,
   output logic                              len_err
);

   localparam int BLOCK_BYTES = block_bytes(BLOCK_W);
   localparam int BYTES_W     = $clog2(BLOCK_BYTES + 1);

   // Oversized byte counts on a last block are clamped to a full block.
   function automatic logic [BYTES_W-1:0] sat_bytes(input logic [BYTES_W-1:0] b);
      if (b > BYTES_W'(BLOCK_BYTES)) return BYTES_W'(BLOCK_BYTES);
      return b;
   endfunction

   fifo_entry_t wr_entry, rd_entry;
   logic        fifo_full, fifo_empty, fifo_pop;
   logic [BYTES_W-1:0] rd_bytes;

   state_t              state_q, state_d;
   logic                init_q, init_d, next_q, next_d, final_q, final_d;
   logic [BLOCK_W-1:0]  block_q, block_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                first_q, first_d;      // next issued block starts a message
   logic                last_q, last_d;        // most recent issue closed a message
   logic                err_q, err_d;
   logic                dv_q, dv_d;
   logic [DIGEST_W-1:0] digest_q, digest_d;

   // Pack the host block into the FIFO entry, zero-filling unused bits.
   always_comb begin
      wr_entry                     = '0;
      wr_entry.block[BLOCK_W-1:0]  = in_block;
      wr_entry.last                = in_last;
      wr_entry.bytes[BYTES_W-1:0]  = in_bytes;
   end

   blake2_block_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (in_valid),
      .pop     (fifo_pop),
      .wdata   (wr_entry),
      .rdata   (rd_entry),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign rd_bytes = rd_entry.bytes[BYTES_W-1:0];

   // Sequencing FSM, command generation, length accumulation and digest capture.
   always_comb begin
      state_d  = state_q;
      init_d   = 1'b0;
      next_d   = 1'b0;
      final_d  = 1'b0;
      dv_d     = 1'b0;
      block_d  = block_q;
      len_d    = len_q;
      first_d  = first_q;
      last_d   = last_q;
      err_d    = err_q;
      digest_d = digest_q;
      fifo_pop = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_ISSUE: begin
            if (!fifo_empty && core_ready) begin
               fifo_pop = 1'b1;
               init_d   = first_q;
               next_d   = !first_q && !rd_entry.last;
               final_d  = rd_entry.last;
               block_d  = rd_entry.block[BLOCK_W-1:0];
               len_d    = (first_q ? '0 : len_q) +
                          (rd_entry.last ? LEN_W'(sat_bytes(rd_bytes)) : LEN_W'(BLOCK_BYTES));
               if (rd_entry.last && (rd_bytes > BYTES_W'(BLOCK_BYTES))) err_d = 1'b1;
               first_d  = 1'b0;
               last_d   = rd_entry.last;
               state_d  = ST_ACK;
            end
         end
         ST_ACK:  state_d = ST_WAIT;
         ST_WAIT: begin
            if (core_ready) state_d = last_q ? ST_DIGEST : ST_ISSUE;
         end
         ST_DIGEST: begin
            if (core_digest_valid) begin
               digest_d = core_digest;
               dv_d     = 1'b1;
               first_d  = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered state and outputs; reset clears everything, including data outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         init_q   <= 1'b0;
         next_q   <= 1'b0;
         final_q  <= 1'b0;
         block_q  <= '0;
         len_q    <= '0;
         first_q  <= 1'b1;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
         dv_q     <= 1'b0;
         digest_q <= '0;
      end else begin
         state_q  <= state_d;
         init_q   <= init_d;
         next_q   <= next_d;
         final_q  <= final_d;
         block_q  <= block_d;
         len_q    <= len_d;
         first_q  <= first_d;
         last_q   <= last_d;
         err_q    <= err_d;
         dv_q     <= dv_d;
         digest_q <= digest_d;
      end
   end

   assign in_ready     = !fifo_full;
   assign core_init    = init_q;
   assign core_next    = next_q;
   assign core_final   = final_q;
   assign core_block   = block_q;
   assign core_length  = len_q;
   assign digest_valid = dv_q;
   assign digest       = digest_q;
   assign len_err      = err_q;
   assign busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_blake2_msg_sequencer.sv
// Directed bench for blake2_msg_sequencer with default parameters.
module tb_blake2_msg_sequencer;

   logic           clk = 1'b0;
   logic           reset_n = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [1023:0]  in_block = '0;
   logic           in_last = 1'b0;
   logic [7:0]     in_bytes = '0;
   logic           core_init, core_next, core_final;
   logic [1023:0]  core_block;
   logic [127:0]   core_length;
   logic           core_ready = 1'b1;
   logic           core_digest_valid = 1'b0;
   logic [87:0]    core_digest = '0;
   logic           digest_valid;
   logic [87:0]    digest;
   logic           busy;
   logic           len_err;

   int checks = 0;
   int errors = 0;

   blake2_msg_sequencer #(
      .BLOCK_W(1024), .DEPTH(8), .LEN_W(128), .DIGEST_W(88)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
      .in_last(in_last), .in_bytes(in_bytes),
      .core_init(core_init), .core_next(core_next), .core_final(core_final),
      .core_block(core_block), .core_length(core_length), .core_ready(core_ready),
      .core_digest_valid(core_digest_valid), .core_digest(core_digest),
      .digest_valid(digest_valid), .digest(digest), .busy(busy), .len_err(len_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1023:0] b, input logic last, input logic [7:0] nb);
      in_valid = 1'b1;
      in_block = b;
      in_last  = last;
      in_bytes = nb;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Waits (bounded) for the next command, sampling on falling edges.
   task automatic wait_cmd(output logic got, output logic [2:0] c, output logic [127:0] len,
                           output logic [7:0] b0, output int cyc);
      got = 1'b0; c = '0; len = '0; b0 = '0; cyc = 0;
      for (int t = 1; t <= 60 && !got; t++) begin
         @(negedge clk);
         if (core_init || core_next || core_final) begin
            got = 1'b1;
            c   = {core_init, core_next, core_final};
            len = core_length;
            b0  = core_block[7:0];
            cyc = t;
         end
      end
   endtask

   // Called right after the final command (or later, while in DIGEST).
   task automatic give_digest(input logic [87:0] d, input string tag);
      repeat (3) @(posedge clk);
      #1;
      core_digest_valid = 1'b1;
      core_digest       = d;
      @(posedge clk); #1;
      core_digest_valid = 1'b0;
      core_digest       = ~d;
      @(negedge clk);
      chk({tag, "_dv_hi"}, digest_valid, 1'b1);
      chk({tag, "_digest"}, digest, d);
      @(negedge clk);
      chk({tag, "_dv_lo"}, digest_valid, 1'b0);
      chk({tag, "_digest_hold"}, digest, d);
   endtask

   logic          g;
   logic [2:0]    c;
   logic [127:0]  l;
   logic [7:0]    b0;
   int            cy;
   logic [1023:0] blk;
   logic          any_cmd;
   logic          gg [10];
   logic [2:0]    cc [10];
   logic [127:0]  ll [10];
   logic [7:0]    bb [10];
   logic          feed_ok;

   initial begin
      // ---------------- reset state
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_cmds", {core_init, core_next, core_final}, 3'b000);
      chk("rst_block", core_block, '0);
      chk("rst_length", core_length, '0);
      chk("rst_digest", digest, '0);
      chk("rst_dv", digest_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_len_err", len_err, 1'b0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // ---------------- stray digest_valid while idle is ignored
      core_digest_valid = 1'b1;
      core_digest       = 88'h55;
      @(posedge clk); #1;
      core_digest_valid = 1'b0;
      @(negedge clk);
      chk("stray_dv", digest_valid, 1'b0);
      chk("stray_digest", digest, '0);

      // ---------------- single-block "abc"
      blk = '0;
      blk[23:0] = 24'h636261;
      push(blk, 1'b1, 8'd3);
      wait_cmd(g, c, l, b0, cy);
      chk("abc_seen", g, 1'b1);
      chk("abc_cmd", c, 3'b101);
      chk("abc_len", l, 128'd3);
      chk("abc_b0", b0, 8'h61);
      chk("abc_latency", cy, 2);
      chk("abc_busy", busy, 1'b1);
      give_digest(88'h0123456789ABCDEF012345, "abc");
      chk("abc_idle", busy, 1'b0);

      // ---------------- two full blocks, second last
      blk = {128{8'h61}};
      push(blk, 1'b0, 8'd0);
      blk = {128{8'h62}};
      push(blk, 1'b1, 8'd128);
      wait_cmd(g, c, l, b0, cy);
      chk("two_a_cmd", c, 3'b100);
      chk("two_a_len", l, 128'd128);
      chk("two_a_b0", b0, 8'h61);
      wait_cmd(g, c, l, b0, cy);
      chk("two_b_cmd", c, 3'b001);
      chk("two_b_len", l, 128'd256);
      chk("two_b_b0", b0, 8'h62);
      chk("two_b_spacing", cy, 3);
      give_digest(88'hAAAA_0000_BBBB_1111_CCCC_22, "two");
      chk("two_len_err", len_err, 1'b0);

      // ---------------- ten blocks with the core held busy
      core_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("fill_rdy", in_ready, 1'b1);
         blk = '0;
         blk[7:0] = 8'(k);
         push(blk, 1'b0, 8'd0);
      end
      chk("full_rdy", in_ready, 1'b0);
      chk("full_busy", busy, 1'b1);
      in_valid = 1'b1;
      in_block = '0;
      in_block[7:0] = 8'd8;
      in_last  = 1'b0;
      in_bytes = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("full_hold_rdy", in_ready, 1'b0);
      core_ready = 1'b1;
      feed_ok = 1'b1;
      fork
         begin
            for (int k = 8; k < 10; k++) begin
               logic acc;
               acc = 1'b0;
               in_block = '0;
               in_block[7:0] = 8'(k);
               in_last  = (k == 9);
               in_bytes = (k == 9) ? 8'd128 : 8'd0;
               in_valid = 1'b1;
               for (int t = 0; t < 100 && !acc; t++) begin
                  acc = in_ready;
                  @(posedge clk); #1;
               end
               if (!acc) feed_ok = 1'b0;
            end
            in_valid = 1'b0;
         end
         begin
            for (int k = 0; k < 10; k++) begin
               logic          tg;
               logic [2:0]    tc;
               logic [127:0]  tl;
               logic [7:0]    tb;
               int            tcy;
               wait_cmd(tg, tc, tl, tb, tcy);
               gg[k] = tg; cc[k] = tc; ll[k] = tl; bb[k] = tb;
            end
         end
      join
      chk("ten_feed", feed_ok, 1'b1);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("ten_seen%0d", k), gg[k], 1'b1);
         chk($sformatf("ten_cmd%0d", k), cc[k], (k == 0) ? 3'b100 : ((k == 9) ? 3'b001 : 3'b010));
         chk($sformatf("ten_len%0d", k), ll[k], 128'(128 * (k + 1)));
         chk($sformatf("ten_b0_%0d", k), bb[k], 8'(k));
      end
      give_digest(88'h10_2030_4050_6070_8090_A0, "ten");

      // ---------------- oversized byte count on a last block
      chk("err_before", len_err, 1'b0);
      blk = '0;
      blk[7:0] = 8'hC8;
      push(blk, 1'b1, 8'd200);
      wait_cmd(g, c, l, b0, cy);
      chk("err_cmd", c, 3'b101);
      chk("err_len", l, 128'd128);
      @(negedge clk);
      chk("err_set", len_err, 1'b1);
      give_digest(88'hE11, "err");
      chk("err_sticky", len_err, 1'b1);

      // ---------------- reset during WAIT of a three-block message
      blk = '0;
      blk[7:0] = 8'h01;
      push(blk, 1'b0, 8'd0);
      wait_cmd(g, c, l, b0, cy);
      chk("mid_cmd", c, 3'b100);
      chk("mid_len", l, 128'd128);
      core_ready = 1'b0;
      blk[7:0] = 8'h02;
      push(blk, 1'b0, 8'd0);
      blk[7:0] = 8'h03;
      push(blk, 1'b1, 8'd64);
      chk("mid_busy", busy, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_cmds", {core_init, core_next, core_final}, 3'b000);
      chk("mid_rst_block", core_block, '0);
      chk("mid_rst_len", core_length, '0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_rdy", in_ready, 1'b1);
      chk("mid_rst_err", len_err, 1'b0);
      chk("mid_rst_digest", digest, '0);
      chk("mid_rst_dv", digest_valid, 1'b0);
      core_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      any_cmd = 1'b0;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         any_cmd = any_cmd | core_init | core_next | core_final | busy;
      end
      chk("mid_quiet", any_cmd, 1'b0);
      blk = '0;
      blk[7:0] = 8'h05;
      push(blk, 1'b1, 8'd5);
      wait_cmd(g, c, l, b0, cy);
      chk("post_cmd", c, 3'b101);
      chk("post_len", l, 128'd5);
      chk("post_latency", cy, 2);
      give_digest(88'h505, "post");

      // ---------------- two queued messages
      blk = '0;
      blk[7:0] = 8'hA1;
      push(blk, 1'b1, 8'd1);
      blk[7:0] = 8'hB2;
      push(blk, 1'b1, 8'd2);
      wait_cmd(g, c, l, b0, cy);
      chk("q_a_cmd", c, 3'b101);
      chk("q_a_len", l, 128'd1);
      any_cmd = 1'b0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         any_cmd = any_cmd | core_init | core_next | core_final;
      end
      chk("q_no_early_init", any_cmd, 1'b0);
      @(posedge clk); #1;
      core_digest_valid = 1'b1;
      core_digest       = 88'hDA;
      @(posedge clk); #1;
      core_digest_valid = 1'b0;
      core_digest       = 88'h0;
      @(negedge clk);
      chk("q_a_dv", digest_valid, 1'b1);
      chk("q_a_digest", digest, 88'hDA);
      wait_cmd(g, c, l, b0, cy);
      chk("q_b_seen", g, 1'b1);
      chk("q_b_after_dv", cy, 1);
      chk("q_b_cmd", c, 3'b101);
      chk("q_b_len", l, 128'd2);
      chk("q_b_b0", b0, 8'hB2);
      chk("q_digest_held", digest, 88'hDA);
      give_digest(88'hDB, "q_b");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
